// File: rtl/sprite_anim_pkg.sv
// Shared types and helpers for the sprite animation sequencer.
// The PINGPONG mode is built only when SPRITE_ANIM_PINGPONG_EN is defined.
package sprite_anim_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_LOOP_ALT = 2'd3
  } anim_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } anim_state_t;

  function automatic int unsigned frame_base(input int unsigned idx, input int unsigned size);
    return idx * size;
  endfunction

endpackage

// File: rtl/anim_prescaler.sv
// Divides the global animation tick: adv_o fires on the pulse that finds the
// count equal to rate_i, so a frame lasts rate_i+1 pulses.
module anim_prescaler
  import sprite_anim_pkg::*;
#(
  parameter int RATE_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              pulse_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              adv_o
);

  logic [RATE_W-1:0] cnt_q, cnt_d;

  assign adv_o = pulse_i && !clear_i && (cnt_q == rate_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (pulse_i) begin
      cnt_d = adv_o ? '0 : cnt_q + RATE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: picks the frame and offsets the sprite ROM address.
// Define SPRITE_ANIM_PINGPONG_EN to build PINGPONG mode (otherwise mode 2 loops).
//   state | meaning
//   IDLE  | enable low, IDLE_FRAME shown
//   RUN   | animating, advancing on prescaled ticks
//   DONE  | ONESHOT finished, last frame held
module sprite_anim_seq
  import sprite_anim_pkg::*;
#(
  parameter int NUM_FRAMES   = 4,
  parameter int FRAME_SIZE   = 1020,
  parameter int IDLE_FRAME   = 0,
  parameter int ACTIVE_FIRST = 0,
  parameter int RATE_W       = 4,
  localparam int SA_W   = $clog2(FRAME_SIZE),
  localparam int ADDR_W = $clog2(NUM_FRAMES * FRAME_SIZE),
  localparam int IDX_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              anim_pulse_i,
  input  logic [1:0]        mode_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              restart_i,
  input  logic [SA_W-1:0]   sprite_addr_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [IDX_W-1:0]  frame_idx_o,
  output logic              active_o,
  output logic              done_o,
  output logic              frame_tick_o
);

  localparam logic [IDX_W-1:0] FIRST    = IDX_W'(ACTIVE_FIRST);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDLE_IDX = IDX_W'(IDLE_FRAME);

  anim_state_t       state_q, state_d;
  logic [IDX_W-1:0]  frame_q, frame_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              tick_q, tick_d;
  logic              adv;
  logic              pre_clear;
  anim_mode_t        mode;
`ifdef SPRITE_ANIM_PINGPONG_EN
  logic              dir_q, dir_d;  // 0 = up, 1 = down
`endif

  assign mode      = anim_mode_t'(mode_i);
  assign pre_clear = (state_q != ST_RUN) || !enable_i || restart_i;

  anim_prescaler #(.RATE_W(RATE_W)) u_prescaler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (pre_clear),
    .pulse_i (anim_pulse_i),
    .rate_i  (rate_i),
    .adv_o   (adv)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tick_d  = 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (!enable_i) begin
      state_d = ST_IDLE;
      frame_d = IDLE_IDX;
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          frame_d = FIRST;
`ifdef SPRITE_ANIM_PINGPONG_EN
          dir_d   = 1'b0;
`endif
        end
        ST_RUN: begin
          if (restart_i) begin
            frame_d = FIRST;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_d   = 1'b0;
`endif
          end else if (adv) begin
            tick_d = 1'b1;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_d  = 1'b0;  // leaving PINGPONG always resumes upward
`endif
            case (mode)
              MODE_ONESHOT: begin
                if (frame_q == LAST) begin
                  state_d = ST_DONE;
                  tick_d  = 1'b0;
                end else begin
                  frame_d = frame_q + IDX_W'(1);
                end
              end
`ifdef SPRITE_ANIM_PINGPONG_EN
              MODE_PINGPONG: begin
                if (!dir_q) begin
                  if (frame_q != LAST) begin
                    frame_d = frame_q + IDX_W'(1);
                  end else if (FIRST != LAST) begin
                    dir_d   = 1'b1;
                    frame_d = frame_q - IDX_W'(1);
                  end
                end else if (frame_q == FIRST) begin
                  frame_d = (FIRST == LAST) ? frame_q : frame_q + IDX_W'(1);
                end else begin
                  dir_d   = 1'b1;
                  frame_d = frame_q - IDX_W'(1);
                end
              end
`endif
              default: frame_d = (frame_q == LAST) ? FIRST : frame_q + IDX_W'(1);
            endcase
          end
        end
        ST_DONE: begin
          if (restart_i) begin
            state_d = ST_RUN;
            frame_d = FIRST;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_d   = 1'b0;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign base_d = ADDR_W'(frame_base(32'(frame_d), FRAME_SIZE));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      frame_q <= IDLE_IDX;
      base_q  <= ADDR_W'(frame_base(IDLE_FRAME, FRAME_SIZE));
      tick_q  <= 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      base_q  <= base_d;
      tick_q  <= tick_d;
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign rom_addr_o   = ADDR_W'(sprite_addr_i) + base_q;
  assign frame_idx_o  = frame_q;
  assign active_o     = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Scoreboard bench for sprite_anim_seq with default parameters; expected frames
// are queued per pulse and checked by a monitor whenever frame_tick fires.
module tb_sprite_anim_seq;

  localparam int SA = 5;
  localparam int FS = 1020;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        anim_pulse_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [3:0]  rate_i = 4'd0;
  logic        restart_i = 1'b0;
  logic [9:0]  sprite_addr_i = 10'(SA);
  logic [11:0] rom_addr_o;
  logic [1:0]  frame_idx_o;
  logic        active_o;
  logic        done_o;
  logic        frame_tick_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int mon_e;
  int pp[10];

  sprite_anim_seq dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .anim_pulse_i (anim_pulse_i),
    .mode_i       (mode_i),
    .rate_i       (rate_i),
    .restart_i    (restart_i),
    .sprite_addr_i(sprite_addr_i),
    .rom_addr_o   (rom_addr_o),
    .frame_idx_o  (frame_idx_o),
    .active_o     (active_o),
    .done_o       (done_o),
    .frame_tick_o (frame_tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input bit exp_tick, input int exp_frame);
    if (exp_tick) exp_q.push_back(exp_frame);
    anim_pulse_i = 1'b1;
    cyc(1);
    anim_pulse_i = 1'b0;
    cyc(1);
  endtask

  task automatic chk_state(input string tag, input int fr, input int act, input int dn);
    chk({tag, "_frame"}, int'(frame_idx_o), fr);
    chk({tag, "_rom_addr"}, int'(rom_addr_o), SA + fr * FS);
    chk({tag, "_active"}, int'(active_o), act);
    chk({tag, "_done"}, int'(done_o), dn);
  endtask

  always @(negedge clk_i) begin
    if (frame_tick_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", int'(frame_idx_o), -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tick_frame", int'(frame_idx_o), mon_e);
        chk("tick_rom_addr", int'(rom_addr_o), SA + mon_e * FS);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SPRITE_ANIM_PINGPONG_EN
    pp = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
`else
    pp = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
`endif
    cyc(2);
    reset_i = 1'b0;
    cyc(1);
    chk_state("reset", 0, 0, 0);
    chk("reset_tick", int'(frame_tick_o), 0);

    // LOOP, rate 0: every pulse advances
    enable_i = 1'b1;
    cyc(1);
    chk_state("enter_run", 0, 1, 0);
    pulse(1, 1); pulse(1, 2); pulse(1, 3);
    chk("loop_rom_at_3", int'(rom_addr_o), 3065);
    pulse(1, 0); pulse(1, 1); pulse(1, 2);

    // rate 2: advance on every third pulse
    rate_i = 4'd2;
    pulse(0, 0); pulse(0, 0);
    chk("rate2_hold", int'(frame_idx_o), 2);
    pulse(1, 3);
    pulse(0, 0); pulse(0, 0); pulse(1, 0);

    // ONESHOT
    rate_i = 4'd0;
    mode_i = 2'd1;
    pulse(1, 1); pulse(1, 2); pulse(1, 3);
    pulse(0, 0);
    chk_state("oneshot_done", 3, 0, 1);
    pulse(0, 0);
    chk("done_hold", int'(frame_idx_o), 3);
    restart_i = 1'b1;
    cyc(1);
    restart_i = 1'b0;
    chk_state("done_restart", 0, 1, 0);
    cyc(1);

    // PINGPONG (LOOP order when the feature is not built), then back to LOOP
    mode_i = 2'd2;
    for (int i = 0; i < 10; i++) pulse(1, pp[i]);
    mode_i = 2'd0;
    pulse(1, 3);
    pulse(1, 0);

    // drop enable mid-RUN, prescaler must be cleared on re-enable
    pulse(1, 1); pulse(1, 2);
    rate_i = 4'd1;
    pulse(0, 0);
    enable_i = 1'b0;
    cyc(1);
    chk_state("disable", 0, 0, 0);
    enable_i = 1'b1;
    cyc(1);
    chk_state("reenable", 0, 1, 0);
    pulse(0, 0);
    pulse(1, 1);

    // restart together with an advancing pulse
    rate_i = 4'd0;
    pulse(1, 2);
    restart_i = 1'b1;
    anim_pulse_i = 1'b1;
    cyc(1);
    restart_i = 1'b0;
    anim_pulse_i = 1'b0;
    chk_state("restart_vs_adv", 0, 1, 0);
    chk("restart_vs_adv_tick", int'(frame_tick_o), 0);
    cyc(1);

    // synchronous reset mid-RUN with a pulse pending
    pulse(1, 1);
    reset_i = 1'b1;
    anim_pulse_i = 1'b1;
    cyc(1);
    chk_state("mid_reset", 0, 0, 0);
    chk("mid_reset_tick", int'(frame_tick_o), 0);
    reset_i = 1'b0;
    anim_pulse_i = 1'b0;
    cyc(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_anim_seq.md
Name: sprite_anim_seq

Overview:
- Parametrised sprite animation sequencer; next generation of the fixed 4-frame flame counter in the ship unit.
- Selects the current animation frame in a multi-frame sprite ROM and produces the ROM address (`sprite_addr + frame base`).
- Supports any frame count and frame size, a programmable frame rate, and LOOP / ONESHOT / PINGPONG modes.
- Sits between Draw_Sprite's `sprite_addr` and the sprite ROM; reused by ship, explosion and asteroid units.

Parameters:
- NUM_FRAMES, 4, total frames stored in the ROM (≥1).
- FRAME_SIZE, 1020, words per frame.
- IDLE_FRAME, 0, frame shown while `enable`=0.
- ACTIVE_FIRST, 0, first frame of the active sequence; the active sequence ends at NUM_FRAMES-1.
- RATE_W, 4, width of the `rate` input.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  animation active (e.g. thrust button); 0 selects IDLE_FRAME.
- anim_pulse  in  1  global animation tick, one cycle wide.
- mode  in  2  0=LOOP, 1=ONESHOT, 2=PINGPONG, 3=LOOP.
- rate  in  RATE_W  anim_pulses per frame minus 1.
- restart  in  1  one-cycle request to restart the sequence.
- sprite_addr  in  $clog2(FRAME_SIZE)  in-frame address from Draw_Sprite.
- rom_addr  out  $clog2(NUM_FRAMES*FRAME_SIZE)  ROM address.
- frame_idx  out  $clog2(NUM_FRAMES) (min 1)  current frame.
- active  out  1  state is RUN.
- done  out  1  state is DONE (ONESHOT finished).
- frame_tick  out  1  one-cycle pulse on every frame advance.

Behaviour:
- Reset (all synchronous): state=IDLE, frame_idx=IDLE_FRAME, anim_base=IDLE_FRAME*FRAME_SIZE, prescaler=0, dir=up, active=0, done=0, frame_tick=0.
- Event priority each cycle: reset > enable=0 > restart > advance.
- rom_addr = sprite_addr + anim_base, combinational, truncated to ADDR_W.
- anim_base is registered and computed from the next frame_idx, so frame_idx and anim_base always change on the same edge.
- Latency: a frame change is visible 1 cycle after the accepting edge.
- States:
  - IDLE:
    - Holds IDLE_FRAME.
    - enable=1 → RUN with frame_idx=ACTIVE_FIRST, prescaler=0, dir=up.
  - RUN:
    - An `anim_pulse` arriving while prescaler==rate is an advance: prescaler←0, frame_tick=1.
    - Any other `anim_pulse` increments the prescaler.
    - LOOP, advance: last frame → ACTIVE_FIRST; otherwise +1.
    - ONESHOT, advance at the last frame: → DONE, frame held, frame_tick=0.
    - PINGPONG, advance: dir=up at the last frame flips to down and steps -1; dir=down at ACTIVE_FIRST flips to up and steps +1.
    - restart=1: frame_idx=ACTIVE_FIRST, prescaler=0, dir=up; no advance that cycle.
  - DONE:
    - Holds the last frame, done=1.
    - restart → RUN at ACTIVE_FIRST.
    - enable=0 → IDLE.
- enable=0 in any state → IDLE next cycle. Prescaler and dir are cleared, and any pending pulse is discarded.
- A mode change takes effect at the next advance only. Switching from PINGPONG to another mode while dir=down sets dir=up at that advance.
- Single active frame (ACTIVE_FIRST==NUM_FRAMES-1):
  - LOOP and PINGPONG hold the frame; frame_tick still pulses on each advance.
  - ONESHOT enters DONE on the first advance.
- rate=0: every anim_pulse advances.

Optional Feature:
- Macro: SPRITE_ANIM_PINGPONG_EN.
- Defined: mode 2 behaves as PINGPONG and the dir register exists.
- Undefined: the dir logic is removed and mode 2 behaves as LOOP.

Decomposition:
- Package sprite_anim_pkg:
  - anim_mode_t enum (LOOP, ONESHOT, PINGPONG, LOOP_ALT).
  - anim_state_t enum (IDLE, RUN, DONE).
  - Function frame_base(idx, size).
- Sub-module anim_prescaler: RATE_W-bit counter.
  - Inputs: clk, reset, clear, pulse, rate.
  - Output: a one-cycle `adv` pulse.

Test Plan:
- LOOP, defaults, rate=0, enable=1, 6 pulses → frame_idx 0,1,2,3,0,1,2; rom_addr with sprite_addr=5 equals 3065 at frame 3; frame_tick once per pulse.
- rate=2 → frame advances every 3rd pulse; no frame_tick on pulses 1-2.
- ONESHOT, ACTIVE_FIRST=1 → frames 1,2,3, then done=1 holding 3; restart → frame 1, active=1, done=0.
- PINGPONG (macro on) → 0,1,2,3,2,1,0,1; with macro off the same stimulus gives LOOP order.
- Drop enable mid-RUN at frame 2 → next cycle frame_idx=IDLE_FRAME, anim_base=0; re-enable restarts at ACTIVE_FIRST with prescaler 0.
- Simultaneous restart and advancing pulse → frame_idx=ACTIVE_FIRST, no frame_tick.
- reset asserted mid-RUN → all outputs at reset values next cycle.
